// File: rtl/zipbus_fairarb_pkg.sv
// Shared owner-state encoding for the two-master bus arbiter.
// No logic, so no latency or backpressure of its own.
package zipbus_fairarb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } owner_t;

endpackage

// File: rtl/zipbus_fairarb.sv
// Shares one pipelined Wishbone bus between data (A, priority) and fetch (B); grant takes one cycle.
// The owner sees the bus stall directly, and the non-owner is held stalled until ownership moves at a cyc boundary.
module zipbus_fairarb
    import zipbus_fairarb_pkg::*;
#(
    parameter int AW       = 30,
    parameter int DW       = 32,
    parameter int LGSTARVE = 4,
    parameter int LGDEPTH  = 5
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    output logic            o_b_starved
);

    localparam logic [LGSTARVE-1:0] STARVE_MAX = '1;
    localparam logic [LGDEPTH-1:0]  DEPTH_MAX  = '1;

    owner_t              owner_q, owner_d;
    logic [LGSTARVE-1:0] starve_q, starve_d;
    logic [LGDEPTH-1:0]  outst_q, outst_d;
    logic                own_a, own_b, own_cyc, own_stb, accept, ack_ok;

    assign o_b_starved = (starve_q == STARVE_MAX);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            owner_q  <= IDLE;
            starve_q <= '0;
            outst_q  <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
            outst_q  <= outst_d;
        end
    end

    // An asserted owner cyc is never preempted, so bus locks survive.
    always_comb begin
        owner_d = owner_q;
        case (owner_q)
            IDLE: begin
                if (i_a_cyc && !(i_b_cyc && o_b_starved))
                    owner_d = OWN_A;
                else if (i_b_cyc)
                    owner_d = OWN_B;
            end
            OWN_A: if (!i_a_cyc) owner_d = i_b_cyc ? OWN_B : IDLE;
            OWN_B: if (!i_b_cyc) owner_d = i_a_cyc ? OWN_A : IDLE;
            default: owner_d = IDLE;
        endcase
    end

    always_comb begin
        own_a     = (owner_q == OWN_A);
        own_b     = (owner_q == OWN_B);
        own_cyc   = (own_a & i_a_cyc) | (own_b & i_b_cyc);
        own_stb   = (own_a & i_a_stb) | (own_b & i_b_stb);
        o_wb_cyc  = own_cyc;
        o_wb_stb  = own_cyc & own_stb;
        o_wb_we   = own_b ? i_b_we   : i_a_we;
        o_wb_addr = own_b ? i_b_addr : i_a_addr;
        o_wb_data = own_b ? i_b_data : i_a_data;
        o_wb_sel  = own_b ? i_b_sel  : i_a_sel;
        accept    = o_wb_stb & ~i_wb_stall;
        ack_ok    = own_cyc & i_wb_ack & (outst_q != '0);
        o_a_stall = own_a ? i_wb_stall : 1'b1;
        o_b_stall = own_b ? i_wb_stall : 1'b1;
        o_a_ack   = own_a & ack_ok;
        o_b_ack   = own_b & ack_ok;
        o_a_err   = own_a & own_cyc & i_wb_err;
        o_b_err   = own_b & own_cyc & i_wb_err;
    end

    always_comb begin
        starve_d = starve_q;
        if (!i_b_cyc || (owner_d == OWN_B && owner_q != OWN_B))
            starve_d = '0;
        else if (owner_q != OWN_B && starve_q != STARVE_MAX)
            starve_d = starve_q + LGSTARVE'(1);
    end

    // Any cycle abort or hand-over forgets pending requests so stale acks are dropped.
    always_comb begin
        outst_d = outst_q;
        if (i_wb_err || !own_cyc || owner_d != owner_q)
            outst_d = '0;
        else if (accept && !ack_ok)
            outst_d = outst_q + LGDEPTH'(1);
        else if (!accept && ack_ok)
            outst_d = outst_q - LGDEPTH'(1);
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(outst_q == DEPTH_MAX && accept && !ack_ok));

endmodule
